// File: rtl/param_sched_pkg.sv
// Shared types and constants for the parameter-entry scheduler: session states,
// completion status codes and the ASCII digit range.
package param_sched_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GRANT_WAIT = 3'd1,
    COLLECT    = 3'd2,
    SAMPLE     = 3'd3,
    RELEASE    = 3'd4
  } sched_state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_RANGE   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/param_config_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Returns a one-hot winner, its index and a valid flag.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [PW-1:0] index,
  output logic          valid
);

  int k;

  // Scan requests starting at ptr; the first hit wins
  always_comb begin
    winner = '0;
    index  = '0;
    valid  = 1'b0;
    k      = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!valid && req[k[PW-1:0]]) begin
        valid              = 1'b1;
        winner[k[PW-1:0]]  = 1'b1;
        index              = k[PW-1:0];
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/param_config_scheduler.sv
// Time-shares one ASCII parameter parser among NUM_SLOTS requesters and latches results.
// Optional build macro PSCHED_DROP_CNT_EN adds drop_cnt, a count of bytes dropped outside sessions.
module param_config_scheduler
  import param_sched_pkg::*;
#(
  parameter int         NUM_SLOTS        = 4,
  parameter logic [7:0] DEFAULT_VALUE    = 8'd10,
  parameter int         SETTLE_CYC       = 100_000,
  parameter int         IDLE_TIMEOUT_CYC = 500_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_rx_done,
  input  logic [7:0]             uart_rx_data,
  input  logic [NUM_SLOTS-1:0]   req,
  output logic [NUM_SLOTS-1:0]   ack,
  output logic [1:0]             ack_status,
  output logic [NUM_SLOTS-1:0]   grant,
  output logic                   busy,
  output logic                   set_enable,
  output logic                   set_rx_done,
  output logic [7:0]             set_rx_data,
  input  logic [7:0]             set_param_value,
  input  logic                   set_param_error,
  output logic [NUM_SLOTS*8-1:0] slot_value,
  output logic [NUM_SLOTS-1:0]   slot_err
`ifdef PSCHED_DROP_CNT_EN
  ,output logic [7:0]            drop_cnt
`endif
);

  localparam int PW = $clog2(NUM_SLOTS);
  localparam int SW = $clog2(SETTLE_CYC);
  localparam int IW = $clog2(IDLE_TIMEOUT_CYC);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [IW-1:0] IDLE_LAST   = IW'(IDLE_TIMEOUT_CYC - 1);
  localparam logic [PW-1:0] SLOT_LAST   = PW'(NUM_SLOTS - 1);

  sched_state_e         state_r;
  logic [NUM_SLOTS-1:0] grant_r;
  logic [PW-1:0]        grant_idx_r;
  logic [PW-1:0]        rr_ptr_r;
  logic [SW-1:0]        settle_cnt_r;
  logic [IW-1:0]        idle_cnt_r;
  logic                 rel_second_r;
  logic [NUM_SLOTS-1:0] ack_r;
  logic [1:0]           ack_status_r;
  logic                 en_r;
  logic [7:0]           slot_val_r [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_err_r;

  logic                 session_s;
  logic                 digit_s;
  logic [NUM_SLOTS-1:0] arb_winner_s;
  logic [PW-1:0]        arb_index_s;
  logic                 arb_valid_s;

  rr_arbiter #(.N(NUM_SLOTS), .PW(PW)) u_arb (
    .req    (req),
    .ptr    (rr_ptr_r),
    .winner (arb_winner_s),
    .index  (arb_index_s),
    .valid  (arb_valid_s)
  );

  // Bytes reach the parser only while a session is collecting input
  assign session_s   = (state_r == GRANT_WAIT) || (state_r == COLLECT);
  assign set_rx_done = uart_rx_done & session_s;
  assign set_rx_data = session_s ? uart_rx_data : 8'h00;
  assign digit_s     = set_rx_done && is_digit(uart_rx_data);

  assign grant      = grant_r;
  assign ack        = ack_r;
  assign ack_status = ack_status_r;
  assign set_enable = en_r;
  assign busy       = (state_r != IDLE);
  assign slot_err   = slot_err_r;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign slot_value[8*g +: 8] = slot_val_r[g];
  end

  // Session sequencer: arbitrate, wait for digits, settle, sample, release
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= '0;
      grant_idx_r  <= '0;
      rr_ptr_r     <= '0;
      settle_cnt_r <= '0;
      idle_cnt_r   <= '0;
      rel_second_r <= 1'b0;
      ack_r        <= '0;
      ack_status_r <= ST_OK;
      en_r         <= 1'b0;
      slot_err_r   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_val_r[i] <= DEFAULT_VALUE;
    end else begin
      ack_r        <= '0;
      ack_status_r <= ST_OK;
      case (state_r)
        IDLE: begin
          if (arb_valid_s) begin
            state_r                  <= GRANT_WAIT;
            grant_r                  <= arb_winner_s;
            grant_idx_r              <= arb_index_s;
            en_r                     <= 1'b1;
            slot_err_r[arb_index_s]  <= 1'b0;
            idle_cnt_r               <= '0;
            rr_ptr_r                 <= (arb_index_s == SLOT_LAST) ? '0 : arb_index_s + PW'(1);
          end
        end
        GRANT_WAIT: begin
          // A digit in the timeout cycle still starts collection
          if (digit_s) begin
            state_r      <= COLLECT;
            settle_cnt_r <= '0;
          end else if (idle_cnt_r == IDLE_LAST) begin
            state_r      <= RELEASE;
            en_r         <= 1'b0;
            ack_r        <= grant_r;
            ack_status_r <= ST_TIMEOUT;
            rel_second_r <= 1'b0;
          end else begin
            idle_cnt_r <= idle_cnt_r + IW'(1);
          end
        end
        COLLECT: begin
          if (digit_s) begin
            settle_cnt_r <= '0;
          end else if (settle_cnt_r == SETTLE_LAST) begin
            state_r <= SAMPLE;
          end else begin
            settle_cnt_r <= settle_cnt_r + SW'(1);
          end
        end
        SAMPLE: begin
          state_r      <= RELEASE;
          en_r         <= 1'b0;
          ack_r        <= grant_r;
          rel_second_r <= 1'b0;
          if (set_param_error) begin
            ack_status_r            <= ST_RANGE;
            slot_err_r[grant_idx_r] <= 1'b1;
          end else begin
            ack_status_r            <= ST_OK;
            slot_val_r[grant_idx_r] <= set_param_value;
          end
        end
        RELEASE: begin
          if (!rel_second_r) begin
            rel_second_r <= 1'b1;
          end else begin
            state_r <= IDLE;
            grant_r <= '0;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= '0;
          en_r    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PSCHED_DROP_CNT_EN
  logic [7:0] drop_cnt_r;
  assign drop_cnt = drop_cnt_r;

  // Saturating count of strobes that arrive with no session to receive them
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= 8'd0;
    end else if (uart_rx_done && !session_s && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_param_config_scheduler.sv
// Bench for param_config_scheduler with a behavioural two-digit parser (accepts 1..50)
// and a reference model of slot contents, round-robin order and completion timing.
module tb_param_config_scheduler;

  localparam int NS        = 4;
  localparam int SETTLE    = 50;
  localparam int IDLE_TO   = 1000;
  localparam int PARSE_MAX = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic          uart_rx_done;
  logic [7:0]    uart_rx_data;
  logic [NS-1:0] req;
  logic [NS-1:0] ack;
  logic [1:0]    ack_status;
  logic [NS-1:0] grant;
  logic          busy;
  logic          set_enable;
  logic          set_rx_done;
  logic [7:0]    set_rx_data;
  logic [7:0]    set_param_value;
  logic          set_param_error;
  logic [NS*8-1:0] slot_value;
  logic [NS-1:0] slot_err;
`ifdef PSCHED_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_val [NS];
  logic [NS-1:0] exp_err;
  int exp_ptr;
  int exp_drops;

  int p_val = 0;
  int p_cnt = 0;
  logic p_err = 1'b0;

  always #5 clk = ~clk;

  param_config_scheduler #(
    .NUM_SLOTS(NS), .DEFAULT_VALUE(8'd10), .SETTLE_CYC(SETTLE), .IDLE_TIMEOUT_CYC(IDLE_TO)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx_done(uart_rx_done), .uart_rx_data(uart_rx_data),
    .req(req), .ack(ack), .ack_status(ack_status), .grant(grant), .busy(busy),
    .set_enable(set_enable), .set_rx_done(set_rx_done), .set_rx_data(set_rx_data),
    .set_param_value(set_param_value), .set_param_error(set_param_error),
    .slot_value(slot_value), .slot_err(slot_err)
`ifdef PSCHED_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  // Parser stand-in: up to two digits, value must lie in 1..PARSE_MAX, error sticky until disable
  always @(posedge clk) begin
    if (set_enable !== 1'b1) begin
      p_val <= 0;
      p_cnt <= 0;
      p_err <= 1'b0;
    end else if (set_rx_done === 1'b1 && set_rx_data >= 8'h30 && set_rx_data <= 8'h39) begin
      p_cnt <= p_cnt + 1;
      if (p_cnt == 0) begin
        p_val <= int'(set_rx_data) - 48;
        p_err <= p_err || (set_rx_data == 8'h30);
      end else if (p_cnt == 1) begin
        p_val <= p_val * 10 + int'(set_rx_data) - 48;
        p_err <= p_err || ((p_val * 10 + int'(set_rx_data) - 48) > PARSE_MAX);
      end else begin
        p_err <= 1'b1;
      end
    end
  end
  assign set_param_value = 8'(p_val);
  assign set_param_error = p_err;

  initial begin
    #(900_000);
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic int rr_pick(input logic [NS-1:0] r, input int ptr);
    for (int i = 0; i < NS; i++) begin
      if (r[(ptr + i) % NS]) return (ptr + i) % NS;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) exp_val[i] = 8'd10;
    exp_err   = '0;
    exp_ptr   = 0;
    exp_drops = 0;
  endtask

  // Pulse one byte; report whether it was forwarded unchanged to the parser
  task automatic send_byte(input logic [7:0] b, output bit fwd);
    uart_rx_data = b;
    uart_rx_done = 1'b1;
    #1;
    fwd = (set_rx_done === 1'b1) && (set_rx_data === b);
    @(posedge clk);
    #1;
    uart_rx_done = 1'b0;
    uart_rx_data = 8'h00;
  endtask

  // One session: v=0 sends nothing, 1..9 one digit, 10..99 two digits.
  // lat counts cycles from the last digit (or from grant when no digits) to ack.
  task automatic run_session(input logic [NS-1:0] reqv, input int v, input int gap,
                             input bit trail, input bit drop_req,
                             output logic [NS-1:0] g, output logic [NS-1:0] a,
                             output logic [1:0] st, output int lat, output bit fwd_all);
    bit f;
    logic [7:0] b;
    g = '0; a = '0; st = 2'b11; lat = 0; fwd_all = 1'b1;
    req = reqv;
    for (int i = 0; i < 20 && busy === 1'b1; i++) tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (grant !== '0) begin
        g = grant;
        break;
      end
    end
    if (g === '0) return;
    if (drop_req) req = '0;
    if (v >= 10) begin
      b = 8'(48 + v / 10);
      send_byte(b, f);
      fwd_all &= f;
      repeat (gap) tick();
    end
    if (v > 0) begin
      b = 8'(48 + v % 10);
      send_byte(b, f);
      fwd_all &= f;
      if (trail) begin
        tick();
        tick();
        send_byte(8'h0D, f);
        fwd_all &= f;
        lat = 3;
      end
    end
    for (int i = 0; i < 1500; i++) begin
      tick();
      lat++;
      if (ack !== '0) begin
        a  = ack;
        st = ack_status;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; uart_rx_done = 1'b0; uart_rx_data = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
    n_tests++;
    if ({grant, ack, ack_status, busy, set_enable, set_rx_done, slot_err} !== '0 || set_rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl got grant=%b ack=%b st=%b busy=%b en=%b want all zero",
               grant, ack, ack_status, busy, set_enable);
    end
    n_tests++;
    if (slot_value !== {NS{8'd10}}) begin
      n_fail++;
      $display("FAIL reset_slots got %h want %h", slot_value, {NS{8'd10}});
    end
  endtask

  task automatic test_single();
    logic [NS-1:0] g, a; logic [1:0] st; int lat; bit fwd; int w;
    w = rr_pick(4'b0001, exp_ptr);
    run_session(4'b0001, 12, 4, 1'b0, 1'b0, g, a, st, lat, fwd);
    req = '0;
    exp_ptr = (w + 1) % NS;
    exp_val[w] = 8'd12;
    n_tests++;
    if (g !== 4'(1 << w) || a !== 4'(1 << w) || st !== 2'b00) begin
      n_fail++;
      $display("FAIL single_ack got grant=%b ack=%b st=%b want %b/%b/00", g, a, st, 4'(1 << w), 4'(1 << w));
    end
    n_tests++;
    if (!fwd || lat != SETTLE + 1) begin
      n_fail++;
      $display("FAIL single_timing got fwd=%0b lat=%0d want 1/%0d", fwd, lat, SETTLE + 1);
    end
    n_tests++;
    if (slot_value[7:0] !== 8'd12) begin
      n_fail++;
      $display("FAIL single_value got %0d want 12", slot_value[7:0]);
    end
    n_tests++;
    if (set_enable !== 1'b0) begin n_fail++; $display("FAIL single_en_low0 got %b want 0", set_enable); end
    tick();
    n_tests++;
    if (set_enable !== 1'b0 || ack !== '0 || grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_release2 got en=%b ack=%b grant=%b want 0/0000/0001", set_enable, ack, grant);
    end
    tick();
    n_tests++;
    if (set_enable !== 1'b0 || grant !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle got en=%b grant=%b busy=%b want 0/0000/0", set_enable, grant, busy);
    end
  endtask

  task automatic test_range_error();
    logic [NS-1:0] g, a; logic [1:0] st; int lat; bit fwd; int w;
    w = rr_pick(4'b0100, exp_ptr);
    run_session(4'b0100, 99, 3, 1'b0, 1'b0, g, a, st, lat, fwd);
    req = '0;
    exp_ptr = (w + 1) % NS;
    exp_err[w] = 1'b1;
    n_tests++;
    if (a !== 4'b0100 || st !== 2'b01) begin
      n_fail++;
      $display("FAIL range_ack got ack=%b st=%b want 0100/01", a, st);
    end
    n_tests++;
    if (slot_err !== exp_err || slot_value[23:16] !== exp_val[2]) begin
      n_fail++;
      $display("FAIL range_slot got err=%b val=%0d want %b/%0d", slot_err, slot_value[23:16], exp_err, exp_val[2]);
    end
  endtask

  task automatic test_round_robin();
    logic [NS-1:0] g, a; logic [1:0] st; int lat; bit fwd; int w;
    for (int s = 0; s < 5; s++) begin
      w = rr_pick(4'b1111, exp_ptr);
      run_session(4'b1111, 7, 1, 1'b0, 1'b0, g, a, st, lat, fwd);
      if (s == 4) req = '0;
      exp_ptr = (w + 1) % NS;
      exp_val[w] = 8'd7;
      exp_err[w] = 1'b0;
      n_tests++;
      if (g !== 4'(1 << w) || a !== 4'(1 << w) || st !== 2'b00) begin
        n_fail++;
        $display("FAIL rr_order s=%0d got grant=%b ack=%b st=%b want slot %0d ok", s, g, a, st, w);
      end
      n_tests++;
      if (slot_err !== exp_err) begin
        n_fail++;
        $display("FAIL rr_slot_err s=%0d got %b want %b", s, slot_err, exp_err);
      end
    end
    n_tests++;
    if (slot_value !== {8'd7, 8'd7, 8'd7, 8'd7}) begin
      n_fail++;
      $display("FAIL rr_values got %h want 07070707", slot_value);
    end
  endtask

  task automatic test_timeout();
    logic [NS-1:0] g, a; logic [1:0] st; int lat; bit fwd; int w;
    w = rr_pick(4'b0010, exp_ptr);
    run_session(4'b0010, 0, 0, 1'b0, 1'b0, g, a, st, lat, fwd);
    req = '0;
    exp_ptr = (w + 1) % NS;
    n_tests++;
    if (a !== 4'b0010 || st !== 2'b10 || lat != IDLE_TO) begin
      n_fail++;
      $display("FAIL timeout_ack got ack=%b st=%b lat=%0d want 0010/10/%0d", a, st, lat, IDLE_TO);
    end
    n_tests++;
    if (slot_value[15:8] !== exp_val[1] || set_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_slot got val=%0d en=%b want %0d/0", slot_value[15:8], set_enable, exp_val[1]);
    end
  endtask

  task automatic test_random();
    logic [NS-1:0] g, a; logic [1:0] st; int lat; bit fwd; int w, v, gap; bit trail, drop;
    logic [NS-1:0] r;
    for (int s = 0; s < 8; s++) begin
      r     = 4'(1 << $urandom_range(NS - 1, 0));
      v     = $urandom_range(99, 1);
      gap   = $urandom_range(8, 1);
      trail = 1'($urandom_range(1, 0));
      drop  = 1'(s % 2);
      w = rr_pick(r, exp_ptr);
      run_session(r, v, gap, trail, drop, g, a, st, lat, fwd);
      req = '0;
      exp_ptr = (w + 1) % NS;
      if (v > PARSE_MAX) exp_err[w] = 1'b1;
      else begin exp_err[w] = 1'b0; exp_val[w] = 8'(v); end
      n_tests++;
      if (g !== r || a !== r || st !== ((v > PARSE_MAX) ? 2'b01 : 2'b00) || !fwd || lat != SETTLE + 1) begin
        n_fail++;
        $display("FAIL rand_session s=%0d v=%0d got grant=%b ack=%b st=%b fwd=%0b lat=%0d want %b/%b/%0d",
                 s, v, g, a, st, fwd, lat, r, r, v > PARSE_MAX);
      end
      n_tests++;
      if (slot_value[8*w +: 8] !== exp_val[w] || slot_err !== exp_err) begin
        n_fail++;
        $display("FAIL rand_slot s=%0d got val=%0d err=%b want %0d/%b", s, slot_value[8*w +: 8], slot_err, exp_val[w], exp_err);
      end
    end
  endtask

  task automatic test_drop_and_reset();
    bit f;
    int acks;
    for (int i = 0; i < 20 && busy === 1'b1; i++) tick();
    send_byte(8'h35, f);
    exp_drops++;
    n_tests++;
    if (f) begin n_fail++; $display("FAIL drop_strobe got forwarded=1 want 0"); end
`ifdef PSCHED_DROP_CNT_EN
    n_tests++;
    if (drop_cnt !== 8'(exp_drops)) begin
      n_fail++;
      $display("FAIL drop_cnt got %0d want %0d", drop_cnt, exp_drops);
    end
`endif
    req = 4'b0001;
    for (int i = 0; i < 10 && grant === '0; i++) tick();
    send_byte(8'h33, f);
    repeat (10) tick();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    model_reset();
    n_tests++;
    if ({grant, ack, busy, set_enable, set_rx_done, slot_err} !== '0 || slot_value !== {NS{8'd10}}) begin
      n_fail++;
      $display("FAIL midreset got grant=%b ack=%b busy=%b en=%b slots=%h want idle/defaults",
               grant, ack, busy, set_enable, slot_value);
    end
`ifdef PSCHED_DROP_CNT_EN
    n_tests++;
    if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL drop_cnt_reset got %0d want 0", drop_cnt); end
`endif
    acks = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ack !== '0 || busy !== 1'b0) acks++;
    end
    n_tests++;
    if (acks != 0) begin n_fail++; $display("FAIL midreset_quiet got %0d active cycles want 0", acks); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_range_error();
    test_round_robin();
    test_timeout();
    test_random();
    test_drop_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_config_scheduler.md
Name: param_config_scheduler

Overview:
- Shares one parameter-entry datapath (ASCII-digit UART parser with 0.5 ms single/double-digit timeout, range check, sticky error until enable drops) among NUM_SLOTS requesters, e.g. mode FSMs needing count, timer or size values.
- Grants round-robin, gates UART bytes to the parser only during a session, and decides completion with a quiet window.
- Samples the parser's value/error into per-slot registers, then releases the parser.

Parameters:
- NUM_SLOTS, 4, number of requesters/parameter slots (2..8).
- DEFAULT_VALUE, 8'd10, reset value of every slot register.
- SETTLE_CYC, 100_000, quiet cycles after the last forwarded digit before sampling. Must exceed parser timeout + 4.
- IDLE_TIMEOUT_CYC, 500_000_000, cycles in GRANT_WAIT without a digit before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- uart_rx_done  in  1  byte strobe from uart_rx
- uart_rx_data  in  8  received byte
- req  in  NUM_SLOTS  level request per slot, held until ack
- ack  out  NUM_SLOTS  one-cycle completion pulse per slot
- ack_status  out  2  valid with ack: 00 ok, 01 range error, 10 timeout
- grant  out  NUM_SLOTS  one-hot current owner
- busy  out  1  session active (state != IDLE)
- set_enable  out  1  enable to parser
- set_rx_done  out  1  gated byte strobe to parser
- set_rx_data  out  8  byte to parser
- set_param_value  in  8  parser output value
- set_param_error  in  1  parser error flag
- slot_value  out  NUM_SLOTS*8  packed slot registers, slot i at [8i+7:8i]
- slot_err  out  NUM_SLOTS  sticky per-slot error, cleared on next grant to that slot

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state IDLE, rr_ptr=0.
  - grant, ack, ack_status, set_enable, set_rx_done, slot_err, busy all 0; set_rx_data 0.
  - every slot_value = DEFAULT_VALUE.
  - Reset mid-session aborts with no ack.
- IDLE:
  - If any req, pick the first set bit at or after rr_ptr (wrapping).
  - Next cycle: grant = that slot, set_enable=1, clear its slot_err, go GRANT_WAIT.
  - rr_ptr := winner+1 mod NUM_SLOTS.
- GRANT_WAIT:
  - All bytes are forwarded combinationally: set_rx_done = uart_rx_done, set_rx_data = uart_rx_data.
  - A digit byte (0x30..0x39) moves to COLLECT and loads settle_cnt=0.
  - Idle counter reaching IDLE_TIMEOUT_CYC-1 moves to RELEASE with status 10.
  - Digit in the same cycle as timeout: digit wins.
- COLLECT:
  - Bytes are forwarded; each digit resets settle_cnt. Non-digits are forwarded and do not reset it.
  - settle_cnt == SETTLE_CYC-1 moves to SAMPLE.
- SAMPLE (1 cycle):
  - set_param_error=1: status 01, set slot_err[g], slot_value unchanged.
  - Else: slot_value[g] := set_param_value, status 00.
  - Go to RELEASE.
- RELEASE (2 cycles):
  - set_enable=0, bytes not forwarded.
  - In the first cycle: ack[g]=1 with ack_status.
  - After the second cycle: grant=0, go IDLE.
  - Next arbitration can occur in the cycle following; minimum enable-low time is 3 cycles.
- Bytes arriving in IDLE, SAMPLE or RELEASE are dropped; set_rx_done stays 0.
- A req deasserted during its own session does not abort it; ack is still pulsed.
- A req that is still high after its ack is treated as a new request under round-robin order.
- Counters are sized $clog2 of their limits and never wrap; each saturates at its terminal compare.

Optional Feature:
- PSCHED_DROP_CNT_EN defined: adds output drop_cnt[7:0], a saturating (255) count of bytes dropped outside sessions. Cleared by rst.
- Undefined: port and logic absent; drops are silent.

Decomposition:
- Package param_sched_pkg holds:
  - state enum (IDLE, GRANT_WAIT, COLLECT, SAMPLE, RELEASE);
  - ack_status codes ST_OK, ST_RANGE, ST_TIMEOUT;
  - ASCII_0/ASCII_9 constants.
- One sub-module rr_arbiter (req, ptr -> one-hot winner, index), combinational, reusable elsewhere.

Test Plan:
- Bench setup: NUM_SLOTS=4, SETTLE_CYC=50, IDLE_TIMEOUT_CYC=1000, real parser with CLK_FREQ=40_000 (20-cycle timeout).
- req=0001, send '1','2' 5 cycles apart -> one grant, ack[0] with status 00, slot_value[0]=12, set_enable low 3 cycles afterward.
- req=0100, send '9','9' -> status 01, slot_err[2]=1, slot_value[2] stays 10. A later successful grant to slot 2 clears slot_err[2].
- req=1111 held, each session sends '7' -> grants in order 0,1,2,3,0. All four slot_values become 7.
- req=0010, no bytes for 1000 cycles -> status 10, ack[1], slot_value[1]=10. Parser returns to idle.
- Send '5' while IDLE, then assert rst mid-COLLECT -> no forwarded strobe, no ack, all outputs at reset values. drop_cnt=1 before reset when PSCHED_DROP_CNT_EN is defined.
